// File: rtl/oled_pkg.sv
// Shared definitions for the OLED start-screen path.
//   OLED_WIDTH / OLED_HEIGHT / OLED_PIXELS : panel geometry
//   R_* / G_* / B_*                        : RGB565 field bit positions
//   fade_state_e                           : start-screen fade sequencer states
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FADE_IN  = 3'd1,
    ST_HOLD     = 3'd2,
    ST_FADE_OUT = 3'd3,
    ST_DONE     = 3'd4
  } fade_state_e;

endpackage

// File: rtl/rgb565_scale.sv
// Combinational brightness scaler for one RGB565 pixel.
//   colour_in  [15:0] : source colour
//   level      [3:0]  : brightness 0..8 (8 = unchanged)
//   colour_out [15:0] : each channel = (channel * level) >> 3, truncated
module rgb565_scale
  import oled_pkg::*;
(
  input  logic [15:0] colour_in,
  input  logic [3:0]  level,
  output logic [15:0] colour_out
);

  // level never exceeds 8, so 8-bit (R/B) and 9-bit (G) products are exact
  // and the >>3 result always fits back in the original channel width.
  logic [7:0] r_prod;
  logic [8:0] g_prod;
  logic [7:0] b_prod;

  assign r_prod = {3'b000, colour_in[R_MSB:R_LSB]} * {4'b0000, level};
  assign g_prod = {3'b000, colour_in[G_MSB:G_LSB]} * {5'b00000, level};
  assign b_prod = {3'b000, colour_in[B_MSB:B_LSB]} * {4'b0000, level};

  assign colour_out = {r_prod[7:3], g_prod[8:3], b_prod[7:3]};

endmodule

// File: rtl/start_screen_fader.sv
// Start-screen fader between the OLED driver and the start-screen renderer.
//   clk, rst_n       : pixel clock, async active-low reset
//   pixel_index      : row-major pixel from the driver
//   frame_begin      : one-cycle frame-start pulse
//   start_btn        : debounced start button level
//   pixel_in         : renderer colour for (x, y)
//   x, y             : combinational coordinates for the renderer
//   pixel_data       : brightness-scaled colour, registered
//   game_start       : one-cycle pulse when the fade-out finishes
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | black, waiting for the first frame_begin
// ST_FADE_IN  | level rises by 1 every FRAMES_PER_STEP frames; press aborts
// ST_HOLD     | full brightness until start is pressed
// ST_FADE_OUT | level falls by 1 every FRAMES_PER_STEP frames
// ST_DONE     | black, terminal until reset; game_start on first cycle
module start_screen_fader
  import oled_pkg::*;
#(
  parameter int WIDTH           = OLED_WIDTH,
  parameter int HEIGHT          = OLED_HEIGHT,
  parameter int FRAMES_PER_STEP = 4,
  parameter int MAX_LEVEL       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  input  logic        frame_begin,
  input  logic        start_btn,
  input  logic [15:0] pixel_in,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [15:0] pixel_data,
  output logic        game_start
);

  localparam logic [12:0] IDX_WIDTH  = 13'(WIDTH);
  localparam logic [12:0] IDX_PIXELS = 13'(WIDTH * HEIGHT);
  localparam logic [3:0]  STEP_LAST  = 4'(FRAMES_PER_STEP - 1);
  localparam logic [3:0]  LEVEL_FULL = 4'(MAX_LEVEL);

  fade_state_e state;
  logic [3:0]  level;
  logic [3:0]  step;
  logic        btn_q;
  logic        press;
  logic        in_range;
  logic [15:0] scaled;

  assign x = 7'(pixel_index % IDX_WIDTH);
  assign y = 6'(pixel_index / IDX_WIDTH);

  assign press    = start_btn & ~btn_q;
  assign in_range = (pixel_index < IDX_PIXELS);

  rgb565_scale u_scale (
    .colour_in  (pixel_in),
    .level      (level),
    .colour_out (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      level      <= 4'd0;
      step       <= 4'd0;
      btn_q      <= 1'b0;
      pixel_data <= 16'h0000;
      game_start <= 1'b0;
    end else begin
      btn_q      <= start_btn;
      game_start <= 1'b0;
      pixel_data <= in_range ? scaled : 16'h0000;

      unique case (state)
        ST_IDLE: begin
          if (frame_begin) begin
            state <= ST_FADE_IN;
            step  <= 4'd0;
          end
        end

        ST_FADE_IN: begin
          // a press beats a coincident frame step: fade out from where we are
          if (press) begin
            state <= ST_FADE_OUT;
            step  <= 4'd0;
          end else if (frame_begin) begin
            if (step == STEP_LAST) begin
              step  <= 4'd0;
              level <= level + 4'd1;
              if (level == LEVEL_FULL - 4'd1) state <= ST_HOLD;
            end else begin
              step <= step + 4'd1;
            end
          end
        end

        ST_HOLD: begin
          if (press) begin
            state <= ST_FADE_OUT;
            step  <= 4'd0;
          end
        end

        ST_FADE_OUT: begin
          if (frame_begin) begin
            if (step == STEP_LAST) begin
              step <= 4'd0;
              // level <= 1 also covers an abort from level 0 without wrapping
              if (level <= 4'd1) begin
                level      <= 4'd0;
                state      <= ST_DONE;
                game_start <= 1'b1;
              end else begin
                level <= level - 4'd1;
              end
            end else begin
              step <= step + 4'd1;
            end
          end
        end

        ST_DONE: begin
        end

        default: begin
          state <= ST_IDLE;
          level <= 4'd0;
          step  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_screen_fader.sv
module tb_start_screen_fader;

  localparam int FPS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] pixel_index = '0;
  logic        frame_begin = 1'b0;
  logic        start_btn = 1'b0;
  logic [15:0] pixel_in = '0;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] pixel_data;
  logic        game_start;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  start_screen_fader #(
    .WIDTH(96), .HEIGHT(64), .FRAMES_PER_STEP(FPS), .MAX_LEVEL(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_index (pixel_index),
    .frame_begin (frame_begin),
    .start_btn   (start_btn),
    .pixel_in    (pixel_in),
    .x           (x),
    .y           (y),
    .pixel_data  (pixel_data),
    .game_start  (game_start)
  );

  // Reference model: level derived from frames counted since the phase began.
  typedef enum {M_IDLE, M_IN, M_HOLD, M_OUT, M_DONE} mmode_e;
  mmode_e      m_mode = M_IDLE;
  int          m_level = 0;
  int          m_frames = 0;
  int          m_out_from = 0;
  bit          m_btn = 1'b0;
  logic [15:0] m_pix = '0;
  bit          m_gs = 1'b0;

  function automatic logic [15:0] ref_scale(logic [15:0] c, int lvl);
    int r, g, b;
    r = int'(c[15:11]) * lvl / 8;
    g = int'(c[10:5])  * lvl / 8;
    b = int'(c[4:0])   * lvl / 8;
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  task automatic tick();
    bit pr;
    pr    = start_btn && !m_btn;
    m_pix = (pixel_index >= 13'd6144) ? 16'h0000 : ref_scale(pixel_in, m_level);
    m_gs  = 1'b0;
    case (m_mode)
      M_IDLE: if (frame_begin) begin m_mode = M_IN; m_frames = 0; end
      M_IN: begin
        if (pr) begin
          m_mode = M_OUT; m_frames = 0; m_out_from = m_level;
        end else if (frame_begin) begin
          m_frames++;
          m_level = m_frames / FPS;
          if (m_level >= 8) m_mode = M_HOLD;
        end
      end
      M_HOLD: if (pr) begin m_mode = M_OUT; m_frames = 0; m_out_from = 8; end
      M_OUT: begin
        if (frame_begin) begin
          m_frames++;
          m_level = m_out_from - m_frames / FPS;
          if (m_level <= 0) begin m_level = 0; m_mode = M_DONE; m_gs = 1'b1; end
        end
      end
      default: ;
    endcase
    m_btn = start_btn;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
  endtask

  task automatic apply_reset(int cycles);
    rst_n = 1'b0;
    m_mode = M_IDLE; m_level = 0; m_frames = 0; m_btn = 1'b0; m_pix = '0; m_gs = 1'b0;
    #1;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_tests++;
    if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL reset_pixel: got %h expected 0000", pixel_data); end
    n_tests++;
    if (game_start !== 1'b0) begin n_fail++; $display("FAIL reset_game_start: got %b expected 0", game_start); end
    pixel_in = 16'hFFFF; pixel_index = 13'd100;
    repeat (3) tick();
    n_tests++;
    if (pixel_data !== m_pix) begin n_fail++; $display("FAIL idle_black: got %h expected %h", pixel_data, m_pix); end
  endtask

  task automatic test_xy();
    int idx [6];
    idx[0] = 0; idx[1] = 95; idx[2] = 96; idx[3] = 6143;
    idx[4] = $urandom_range(0, 6143); idx[5] = $urandom_range(0, 6143);
    foreach (idx[i]) begin
      pixel_index = 13'(idx[i]);
      #1;
      n_tests++;
      if (x !== 7'(idx[i] % 96) || y !== 6'(idx[i] / 96)) begin
        n_fail++;
        $display("FAIL xy idx=%0d: got x=%0d y=%0d expected x=%0d y=%0d", idx[i], x, y, idx[i] % 96, idx[i] / 96);
      end
    end
  endtask

  task automatic test_fade_in();
    bit did_l4 = 1'b0;
    for (int f = 0; f < 33; f++) begin
      pixel_in = 16'($urandom); pixel_index = 13'($urandom_range(0, 6143));
      send_frame();
      n_tests++;
      if (pixel_data !== m_pix) begin n_fail++; $display("FAIL fade_in_frame%0d: got %h expected %h", f, pixel_data, m_pix); end
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        if (m_level == 4 && !did_l4) pixel_in = 16'hFFFF;
        else pixel_in = 16'($urandom);
        pixel_index = 13'($urandom_range(0, 6143));
        tick();
        n_tests++;
        if (pixel_data !== m_pix || game_start !== 1'b0) begin
          n_fail++; $display("FAIL fade_in_gap%0d: got %h/%b expected %h/0", f, pixel_data, game_start, m_pix);
        end
        if (pixel_in == 16'hFFFF && m_level == 4 && !did_l4) begin
          did_l4 = 1'b1;
          n_tests++;
          if (pixel_data !== 16'h7BEF) begin n_fail++; $display("FAIL level4_ffff: got %h expected 7BEF", pixel_data); end
        end
      end
    end
    pixel_in = 16'hFFC2; pixel_index = 13'd777;
    tick();
    n_tests++;
    if (pixel_data !== 16'hFFC2) begin n_fail++; $display("FAIL hold_passthru: got %h expected FFC2", pixel_data); end
    pixel_index = 13'd6144;
    tick();
    n_tests++;
    if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL out_of_range: got %h expected 0000", pixel_data); end
    pixel_index = 13'd0;
  endtask

  task automatic test_hold_press_simul();
    int frames_out = 0;
    int gs_count = 0;
    start_btn = 1'b1; pixel_in = 16'hFFFF; pixel_index = 13'd10;
    send_frame();
    tick();
    n_tests++;
    if (pixel_data !== 16'hFFFF || pixel_data !== m_pix) begin
      n_fail++; $display("FAIL simul_press_level: got %h expected FFFF", pixel_data);
    end
    for (int c = 0; c < 100; c++) begin
      pixel_in = 16'($urandom); pixel_index = 13'($urandom_range(0, 6143));
      frame_begin = (c % 5 == 4);
      if (frame_begin) frames_out++;
      tick();
      frame_begin = 1'b0;
      gs_count += int'(game_start);
      n_tests++;
      if (pixel_data !== m_pix || game_start !== m_gs) begin
        n_fail++; $display("FAIL held_btn c=%0d: got %h/%b expected %h/%b", c, pixel_data, game_start, m_pix, m_gs);
      end
    end
    start_btn = 1'b0;
    for (int c = 0; c < 200 && gs_count == 0; c++) begin
      pixel_in = 16'($urandom);
      send_frame();
      frames_out++;
      gs_count += int'(game_start);
      n_tests++;
      if (pixel_data !== m_pix || game_start !== m_gs) begin
        n_fail++; $display("FAIL fade_out c=%0d: got %h/%b expected %h/%b", c, pixel_data, game_start, m_pix, m_gs);
      end
    end
    n_tests++;
    if (frames_out !== 32) begin n_fail++; $display("FAIL fade_out_len: got %0d frames expected 32", frames_out); end
    for (int c = 0; c < 6; c++) begin
      pixel_in = 16'hFFFF; start_btn = c[0]; frame_begin = c[1];
      tick();
      gs_count += int'(game_start);
      n_tests++;
      if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL done_black c=%0d: got %h expected 0000", c, pixel_data); end
    end
    start_btn = 1'b0; frame_begin = 1'b0;
    n_tests++;
    if (gs_count !== 1) begin n_fail++; $display("FAIL game_start_pulses: got %0d expected 1", gs_count); end
  endtask

  task automatic test_press_fade_in();
    int frames_out = 0;
    bit seen = 1'b0;
    apply_reset(2);
    pixel_in = 16'hFFFF; pixel_index = 13'd50;
    send_frame();
    repeat (12) begin send_frame(); tick(); end
    n_tests++;
    if (pixel_data !== 16'h5AEB) begin n_fail++; $display("FAIL level3_ffff: got %h expected 5AEB", pixel_data); end
    start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
    for (int c = 0; c < 40 && !seen; c++) begin
      pixel_in = 16'($urandom);
      send_frame();
      frames_out++;
      seen = game_start;
      n_tests++;
      if (pixel_data !== m_pix) begin n_fail++; $display("FAIL abort_fade c=%0d: got %h expected %h", c, pixel_data, m_pix); end
    end
    n_tests++;
    if (frames_out !== 12 || !seen) begin n_fail++; $display("FAIL abort_len: got %0d frames (gs=%b) expected 12", frames_out, seen); end
    pixel_in = 16'hFFFF;
    tick();
    n_tests++;
    if (game_start !== 1'b0 || pixel_data !== 16'h0000) begin
      n_fail++; $display("FAIL after_done: got %h/%b expected 0000/0", pixel_data, game_start);
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset(2);
    send_frame();
    repeat (32) send_frame();
    start_btn = 1'b0; pixel_in = 16'hFFFF; pixel_index = 13'd5;
    tick();
    n_tests++;
    if (pixel_data !== 16'hFFFF) begin n_fail++; $display("FAIL hold_reached: got %h expected FFFF", pixel_data); end
    apply_reset(3);
    n_tests++;
    if (pixel_data !== 16'h0000 || game_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_hold: got %h/%b expected 0000/0", pixel_data, game_start);
    end
    start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
    send_frame();
    repeat (3) send_frame();
    tick();
    n_tests++;
    if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL restart_3frames: got %h expected 0000", pixel_data); end
    send_frame();
    tick();
    n_tests++;
    if (pixel_data !== 16'h18E3 || pixel_data !== m_pix) begin
      n_fail++; $display("FAIL restart_level1: got %h expected 18E3", pixel_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_xy();
    test_fade_in();
    test_hold_press_simul();
    test_press_fade_in();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
